// File: rtl/fruit_split_seq_if.sv
// Game-logic <-> fruit sequencer bundle: launch/slice requests in, sprite half controls out.
// The sequencer side is the slave; the game logic or testbench drives through the master side.
interface fruit_split_seq_if;
  logic              frame_tick;
  logic              launch;
  logic [9:0]        launch_x;
  logic signed [5:0] launch_vx;
  logic signed [7:0] launch_vy;
  logic [9:0]        obj_w;
  logic              slice;
  logic              busy;
  logic              en1;
  logic              en2;
  logic [9:0]        posx1;
  logic [9:0]        posx2;
  logic [9:0]        posy1;
  logic [9:0]        posy2;
  logic              missed;
  logic              done;

  modport master (
    output frame_tick, launch, launch_x, launch_vx, launch_vy, obj_w, slice,
    input  busy, en1, en2, posx1, posx2, posy1, posy2, missed, done
  );

  modport slave (
    input  frame_tick, launch, launch_x, launch_vx, launch_vy, obj_w, slice,
    output busy, en1, en2, posx1, posx2, posy1, posy2, missed, done
  );
endinterface

// File: rtl/fruit_split_seq.sv
// Per-fruit ballistic sequencer: launch, per-frame integration, slice into two drifting halves, retire.
// Outputs are registered on the frame_tick edge and held for the rest of the frame; no backpressure.
module fruit_split_seq #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int GRAVITY  = 1,
  parameter int SPLIT_DX = 2
) (
  input logic              clk,
  input logic              rst_n,
  fruit_split_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, SPLIT = 2'd2} state_t;

  localparam logic signed [13:0] W_L = 14'(SCREEN_W);
  localparam logic signed [13:0] H_L = 14'(SCREEN_H);

  state_t             state_q, state_d;
  logic signed [11:0] x_q, x_d, y_q, y_d;
  logic signed [5:0]  vx_q, vx_d;
  logic signed [8:0]  vy_q, vy_d;
  logic [9:0]         w_q, w_d, sep_q, sep_d;
  logic               slice_pend_q, slice_pend_d;
  logic               en1_q, en1_d, en2_q, en2_d;
  logic               missed_q, missed_d, done_q, done_d;
  logic [9:0]         posx1_q, posx1_d, posx2_q, posx2_d;
  logic [9:0]         posy1_q, posy1_d, posy2_q, posy2_d;

  // Candidate post-tick values, computed from current state only so the FSM has no comb loop.
  logic signed [11:0] x_nxt, y_nxt;
  logic signed [8:0]  vy_nxt;
  logic [10:0]        sep_sum;
  logic [9:0]         sep_adv, sep_nxt;
  logic signed [13:0] x_w, y_w, xr_fly, xl_spl, xr_spl;
  logic               off_bot, y_on, slice_now;
  logic signed [13:0] xa, xb;

  assign x_nxt   = x_q + {{6{vx_q[5]}}, vx_q};
  assign y_nxt   = y_q + {{3{vy_q[8]}}, vy_q};
  assign vy_nxt  = vy_q + 9'(GRAVITY);
  assign sep_sum = {1'b0, sep_q} + 11'(SPLIT_DX);
  assign sep_adv = (sep_sum > 11'd1023) ? 10'd1023 : sep_sum[9:0];
  assign sep_nxt = (state_q == FLY) ? 10'(SPLIT_DX) : sep_adv;
  assign x_w     = {{2{x_nxt[11]}}, x_nxt};
  assign y_w     = {{2{y_nxt[11]}}, y_nxt};
  assign xr_fly  = x_w + ({4'd0, w_q} >> 1);
  assign xl_spl  = x_w - {4'd0, sep_nxt};
  assign xr_spl  = xr_fly + {4'd0, sep_nxt};
  assign off_bot = (y_w >= H_L) && (vy_nxt > 9'sd0);
  assign y_on    = !y_w[13] && (y_w < H_L);
  assign slice_now = slice_pend_q || bus.slice;

  function automatic logic on_x(input logic signed [13:0] v);
    return !v[13] && (v < W_L);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      w_q          <= '0;
      sep_q        <= '0;
      slice_pend_q <= 1'b0;
      en1_q        <= 1'b0;
      en2_q        <= 1'b0;
      missed_q     <= 1'b0;
      done_q       <= 1'b0;
      posx1_q      <= '0;
      posx2_q      <= '0;
      posy1_q      <= '0;
      posy2_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      w_q          <= w_d;
      sep_q        <= sep_d;
      slice_pend_q <= slice_pend_d;
      en1_q        <= en1_d;
      en2_q        <= en2_d;
      missed_q     <= missed_d;
      done_q       <= done_d;
      posx1_q      <= posx1_d;
      posx2_q      <= posx2_d;
      posy1_q      <= posy1_d;
      posy2_q      <= posy2_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    w_d          = w_q;
    sep_d        = sep_q;
    slice_pend_d = slice_pend_q;
    unique case (state_q)
      IDLE: begin
        if (bus.launch) begin
          state_d      = FLY;
          x_d          = {2'b00, bus.launch_x};
          y_d          = 12'(SCREEN_H);
          vx_d         = bus.launch_vx;
          vy_d         = {bus.launch_vy[7], bus.launch_vy};
          w_d          = bus.obj_w;
          sep_d        = '0;
          slice_pend_d = 1'b0;
        end
      end
      FLY: begin
        if (bus.frame_tick) begin
          x_d  = x_nxt;
          y_d  = y_nxt;
          vy_d = vy_nxt;
          if (slice_now) begin
            state_d      = SPLIT;
            sep_d        = sep_nxt;
            slice_pend_d = 1'b0;
          end else if (off_bot) begin
            state_d = IDLE;
          end
        end else if (bus.slice) begin
          slice_pend_d = 1'b1;
        end
      end
      SPLIT: begin
        if (bus.frame_tick) begin
          x_d   = x_nxt;
          y_d   = y_nxt;
          vy_d  = vy_nxt;
          sep_d = sep_nxt;
          if (off_bot || (xl_spl[13] && !on_x(xr_spl) && !xr_spl[13]))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each half keeps its last position while hidden so the sprite engine never sees a jump.
  always_comb begin
    en1_d    = en1_q;
    en2_d    = en2_q;
    posx1_d  = posx1_q;
    posx2_d  = posx2_q;
    posy1_d  = posy1_q;
    posy2_d  = posy2_q;
    missed_d = 1'b0;
    done_d   = 1'b0;
    xa       = (state_d == SPLIT) ? xl_spl : x_w;
    xb       = (state_d == SPLIT) ? xr_spl : xr_fly;
    if (state_q != IDLE && bus.frame_tick) begin
      if (state_d == IDLE) begin
        en1_d    = 1'b0;
        en2_d    = 1'b0;
        missed_d = (state_q == FLY);
        done_d   = (state_q == SPLIT);
      end else begin
        en1_d = y_on && on_x(xa);
        en2_d = y_on && on_x(xb);
        if (en1_d) begin
          posx1_d = xa[9:0];
          posy1_d = y_nxt[9:0];
        end
        if (en2_d) begin
          posx2_d = xb[9:0];
          posy2_d = y_nxt[9:0];
        end
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.en1    = en1_q;
  assign bus.en2    = en2_q;
  assign bus.posx1  = posx1_q;
  assign bus.posx2  = posx2_q;
  assign bus.posy1  = posy1_q;
  assign bus.posy2  = posy2_q;
  assign bus.missed = missed_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_fruit_split_seq.sv
// Directed bench for fruit_split_seq: launch, miss, slice split, edge-exit, ignored launch, mid-flight reset.
module tb_fruit_split_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fruit_split_seq_if bus ();

  fruit_split_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Two quiet cycles, then a one-cycle frame_tick; returns just after the sampling edge.
  task automatic tick();
    cyc();
    cyc();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_launch(input logic [9:0] x, input logic signed [5:0] vx,
                           input logic signed [7:0] vy, input logic [9:0] w, input logic with_slice);
    bus.launch_x  = x;
    bus.launch_vx = vx;
    bus.launch_vy = vy;
    bus.obj_w     = w;
    bus.launch    = 1'b1;
    bus.slice     = with_slice;
    cyc();
    bus.launch    = 1'b0;
    bus.slice     = 1'b0;
  endtask

  task automatic do_slice();
    bus.slice = 1'b1;
    cyc();
    bus.slice = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.launch     = 1'b0;
    bus.launch_x   = '0;
    bus.launch_vx  = '0;
    bus.launch_vy  = '0;
    bus.obj_w      = '0;
    bus.slice      = 1'b0;
    cyc();
    cyc();
    check("rst_busy", bus.busy, 0);
    check("rst_en1", bus.en1, 0);
    check("rst_posx2", bus.posx2, 0);
    check("rst_missed", bus.missed, 0);
    rst_n = 1'b1;
    cyc();

    // Slice while idle must not leave anything behind.
    do_slice();
    check("idle_slice_busy", bus.busy, 0);

    // Test 1 + test 5: vertical launch, ignored relaunch while busy.
    do_launch(10'd300, 6'sd0, -8'sd10, 10'd64, 1'b0);
    check("t1_busy", bus.busy, 1);
    check("t1_pre_en1", bus.en1, 0);
    tick();
    check("t1_posx1", bus.posx1, 300);
    check("t1_posx2", bus.posx2, 332);
    check("t1_posy1", bus.posy1, 470);
    check("t1_posy2", bus.posy2, 470);
    check("t1_en1", bus.en1, 1);
    check("t1_en2", bus.en2, 1);
    do_launch(10'd500, 6'sd5, -8'sd20, 10'd100, 1'b0);
    check("t5_busy", bus.busy, 1);
    ticks(4);
    check("t1_tick5_posy", bus.posy1, 440);
    check("t5_posx1", bus.posx1, 300);
    check("t5_posx2", bus.posx2, 332);

    // Test 2: fall off the bottom unsliced at tick 21.
    ticks(15);
    check("t2_tick20_posy", bus.posy1, 470);
    check("t2_tick20_en1", bus.en1, 1);
    tick();
    check("t2_en1", bus.en1, 0);
    check("t2_en2", bus.en2, 0);
    check("t2_missed", bus.missed, 1);
    check("t2_busy", bus.busy, 0);
    check("t2_done", bus.done, 0);
    check("t2_posx1_hold", bus.posx1, 300);

    // Test 3: launch in first idle cycle, slice between tick 4 and 5.
    do_launch(10'd300, 6'sd0, -8'sd10, 10'd64, 1'b0);
    check("t2_missed_pulse_end", bus.missed, 0);
    check("t3_busy", bus.busy, 1);
    ticks(4);
    check("t3_tick4_posx1", bus.posx1, 300);
    do_slice();
    tick();
    check("t3_tick5_posx1", bus.posx1, 298);
    check("t3_tick5_posx2", bus.posx2, 334);
    check("t3_tick5_posy", bus.posy1, 440);
    tick();
    check("t3_tick6_posx1", bus.posx1, 296);
    check("t3_tick6_posx2", bus.posx2, 336);

    // Test 6: asynchronous reset in SPLIT.
    rst_n = 1'b0;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_en1", bus.en1, 0);
    check("t6_en2", bus.en2, 0);
    check("t6_posx1", bus.posx1, 0);
    check("t6_posy1", bus.posy1, 0);
    cyc();
    check("t6_done", bus.done, 0);
    rst_n = 1'b1;
    cyc();
    // Relaunch with a simultaneous slice: launch wins, slice is dropped.
    do_launch(10'd300, 6'sd0, -8'sd10, 10'd64, 1'b1);
    tick();
    check("t6_relaunch_posx1", bus.posx1, 300);
    check("t6_relaunch_posx2", bus.posx2, 332);
    check("t6_relaunch_posy", bus.posy1, 470);
    tick();
    check("t6_no_pend_posx1", bus.posx1, 300);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Test 4: drift left; left half leaves the screen, right half retires at the bottom.
    do_launch(10'd10, -6'sd3, -8'sd10, 10'd64, 1'b0);
    do_slice();
    tick();
    check("t4_tick1_posx1", bus.posx1, 5);
    check("t4_tick1_posx2", bus.posx2, 41);
    tick();
    check("t4_tick2_posx1", bus.posx1, 0);
    check("t4_tick2_en1", bus.en1, 1);
    tick();
    check("t4_tick3_en1", bus.en1, 0);
    check("t4_tick3_en2", bus.en2, 1);
    check("t4_tick3_posx1_hold", bus.posx1, 0);
    check("t4_tick3_posx2", bus.posx2, 39);
    ticks(17);
    check("t4_tick20_en2", bus.en2, 1);
    check("t4_tick20_posx2", bus.posx2, 22);
    check("t4_tick20_done", bus.done, 0);
    tick();
    check("t4_done", bus.done, 1);
    check("t4_en2", bus.en2, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_missed", bus.missed, 0);
    cyc();
    check("t4_done_pulse_end", bus.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
